uart_tx_fifo_feeder: RTL and testbench
======================================

// Module: uart_tx_fifo_feeder
// PURPOSE
// - Buffers parallel bytes from the host and launches them one at a time into the UART TX stage.
// - Drives P_DATA and a one-cycle Data_Valid pulse only when TX is idle (busy low).
// - Holds P_DATA stable until the frame completes.
// - Sits directly upstream of the TX controller/serializer; consumes its busy output.
// PARAMETERS
// - DATA_WIDTH    8  byte width of FIFO entries and P_DATA
// - DEPTH         8  FIFO entries; power of two, >= 2
// - ADDR_WIDTH    3  log2(DEPTH)
// - BUSY_TIMEOUT  4  cycles to wait for busy to rise after a launch before abandoning the handshake; >= 2
// PORTS
// - clk         in   1           single clock, rising edge
// - rst         in   1           asynchronous, active-low reset
// - wr_en       in   1           host write strobe
// - wr_data     in   DATA_WIDTH  host byte
// - full        out  1           FIFO holds DEPTH entries
// - empty       out  1           FIFO holds 0 entries
// - count       out  ADDR_WIDTH+1  entries currently stored
// - wr_overflow out  1           one-cycle pulse: write attempted while full (byte dropped)
// - busy        in   1           from TX controller; high while a frame is on the line
// - P_DATA      out  DATA_WIDTH  byte presented to the serializer/parity stage
// - Data_Valid  out  1           one-cycle launch pulse to the TX controller
// - tx_timeout  out  1           one-cycle pulse: busy never rose within BUSY_TIMEOUT
// BEHAVIOUR
// - Reset (rst=0, async):
//   - Pointers and count = 0; empty = 1; full = 0.
//   - P_DATA = 0; Data_Valid = 0; wr_overflow = 0; tx_timeout = 0; state = IDLE.
//   - Memory contents are not reset.
// - FIFO:
//   - Pointers are ADDR_WIDTH+1 bits with natural wrap.
//   - full/empty/count are registered and derive from count.
//   - A write is accepted iff wr_en && !full, judged on the registered full. A same-cycle pop does not free space for that write.
//   - A pop occurs only on the IDLE->LAUNCH transition.
//   - Simultaneous accepted write and pop leaves count unchanged.
//   - Write while full: data dropped, wr_overflow pulses for 1 cycle.
// - Launch FSM: states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE. All outputs are registered.
//   - IDLE: when !empty && !busy:
//     - P_DATA <= mem[rd_ptr]; rd_ptr++, count-- (unless a same-cycle write).
//     - Next state LAUNCH.
//   - LAUNCH: Data_Valid = 1 for exactly this cycle. Next state WAIT_BUSY; timeout counter cleared.
//   - WAIT_BUSY:
//     - busy=1 -> WAIT_DONE.
//     - Otherwise the counter increments; on reaching BUSY_TIMEOUT -> IDLE with a tx_timeout pulse. The byte is considered consumed and is not retried.
//   - WAIT_DONE: busy=0 -> IDLE.
//   - P_DATA is held from the IDLE->LAUNCH edge until the next pop. It never changes while busy=1.
// - Latency:
//   - Write into an empty FIFO with idle TX: Data_Valid high 2 cycles after the wr_en edge (1 cycle for count/empty update, 1 cycle for the launch register).
//   - Back-to-back bytes: next Data_Valid no earlier than 2 cycles after busy falls.
// - Boundaries:
//   - busy already high in IDLE (frame from another source): no pop until busy falls.
//   - busy glitching low in WAIT_DONE ends the frame; the next launch follows the normal IDLE rules.
//   - Reset mid-frame returns to IDLE with the FIFO emptied. Data_Valid drops immediately (async).
//   - count never exceeds DEPTH and never underflows; a pop is never issued when empty.
// STRUCTURE
// - Shared package uart_pkg:
//   - Launch-FSM state encodings (IDLE=2'b00, LAUNCH=2'b01, WAIT_BUSY=2'b10, WAIT_DONE=2'b11).
//   - Default DATA_WIDTH.
// - One sub-module, uart_sync_fifo: mem, pointers, count, full/empty, overflow. Exposes rd_data = mem[rd_ptr] plus a pop strobe.
// - Top level holds the launch FSM, timeout counter, P_DATA/Data_Valid registers.
// TESTING
// - Reset then idle, busy=0, no writes -> Data_Valid stays 0 for 50 cycles; empty=1, count=0.
// - Single write 8'hA5, busy=0; model busy rising 1 cycle after Data_Valid for 10 cycles -> exactly one Data_Valid pulse 2 cycles after the write; P_DATA=8'hA5 held throughout busy; empty=1 afterwards.
// - Burst of 9 writes (8'h01..8'h09) with busy=1 held -> count=8, full=1; the 9th write pulses wr_overflow; then release busy -> bytes 01..08 launched in order, one per busy low-high-low cycle.
// - Launch with busy never rising -> tx_timeout pulses at BUSY_TIMEOUT=4 cycles after LAUNCH; FSM back in IDLE; the next queued byte launches.
// - Simultaneous write and pop at count=3 -> count stays 3; written byte emerges after the existing two.
// - Assert rst in WAIT_DONE with 5 entries queued -> Data_Valid=0, P_DATA=0, count=0, empty=1 immediately; no launch until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX feed path.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LAUNCH    = 2'b01,
    WAIT_BUSY = 2'b10,
    WAIT_DONE = 2'b11
  } launch_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO feeding the UART launch FSM. Status flags are registered
// and derived from the registered occupancy count. A pop never frees space for
// a write in the same cycle: both are judged on the registered flags.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_overflow
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_ok;
  logic                  rd_ok;

  assign wr_ok   = wr_en && !full;
  assign rd_ok   = pop && !empty;
  assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Next occupancy: a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + ONE;
      2'b01:   count_next = count - ONE;
      default: count_next = count;
    endcase
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

  // Pointers, occupancy, status flags and the overflow pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      wr_overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ONE;
      if (rd_ok) rd_ptr <= rd_ptr + ONE;
      count       <= count_next;
      full        <= (count_next == FULL_CNT);
      empty       <= (count_next == '0);
      wr_overflow <= wr_en && full;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_feeder.sv
// Buffers host bytes and launches them one at a time into the UART TX
// controller, waiting for its busy flag to rise and fall around each frame.
//
// state     | meaning
// IDLE      | waiting for a queued byte and busy low; pops on exit
// LAUNCH    | Data_Valid high for this single cycle
// WAIT_BUSY | waiting for TX to acknowledge with busy; gives up after timeout
// WAIT_DONE | frame on the line; leave when busy falls
module uart_tx_fifo_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_overflow,
  input  logic                  busy,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  tx_timeout
);

  // Down-counter loaded in LAUNCH; busy is watched for BUSY_TIMEOUT-1 cycles
  // of WAIT_BUSY, so the timeout pulse lands BUSY_TIMEOUT cycles after the
  // Data_Valid cycle.
  localparam int             TW       = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMR_LOAD = TW'(BUSY_TIMEOUT - 2);
  localparam logic [TW-1:0]  TMR_ONE  = TW'(1);

  launch_state_t         state;
  launch_state_t         state_next;
  logic                  pop;
  logic                  timeout_hit;
  logic [TW-1:0]         tmr;
  logic [DATA_WIDTH-1:0] rd_data;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .pop         (pop),
    .rd_data     (rd_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .wr_overflow (wr_overflow)
  );

  assign timeout_hit = (state == WAIT_BUSY) && !busy && (tmr == '0);

  // Next-state logic and the pop strobe (only on IDLE -> LAUNCH).
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !busy) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy)             state_next = WAIT_DONE;
        else if (tmr == '0)   state_next = IDLE;
      end
      WAIT_DONE: if (!busy)   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Registered outputs and the busy-acknowledge timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      tx_timeout <= 1'b0;
      tmr        <= '0;
    end else begin
      if (pop) P_DATA <= rd_data;
      Data_Valid <= pop;
      tx_timeout <= timeout_hit;
      if (state == LAUNCH)
        tmr <= TMR_LOAD;
      else if ((state == WAIT_BUSY) && !busy && (tmr != '0))
        tmr <= tmr - TMR_ONE;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Scoreboard bench for uart_tx_fifo_feeder: a queue model of the FIFO is fed
// on accepted writes, and a negedge monitor pops it on every Data_Valid.
module tb_uart_tx_fifo_feeder;

  localparam int DEPTH = 8;
  localparam int BT    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, wr_overflow, Data_Valid, tx_timeout;
  logic [3:0] count;
  logic [7:0] P_DATA;
  logic       busy;
  logic       host_busy = 1'b0;
  logic       frame_busy = 1'b0;

  assign busy = host_busy | frame_busy;

  uart_tx_fifo_feeder #(
    .DATA_WIDTH (8), .DEPTH (DEPTH), .ADDR_WIDTH (3), .BUSY_TIMEOUT (BT)
  ) dut (
    .clk (clk), .rst (rst), .wr_en (wr_en), .wr_data (wr_data),
    .full (full), .empty (empty), .count (count), .wr_overflow (wr_overflow),
    .busy (busy), .P_DATA (P_DATA), .Data_Valid (Data_Valid), .tx_timeout (tx_timeout)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] q[$];
  int         cyc = 0;
  logic       exp_ovf = 1'b0;
  int         dv_total = 0, to_total = 0, ovf_total = 0, last_dv_cyc = -100;
  int         age = 99;
  logic       busy_seen = 1'b0;
  logic [7:0] last_pdata = 8'h00;
  logic [7:0] exp_b;
  int         resp_mode = 0;   // 0 always answer, 1 never, 2 random
  int         frame_len = 10;  // 0 = random length per frame
  int         frame_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: accept a write only when fewer than DEPTH bytes are held.
  always @(posedge clk) begin
    cyc = cyc + 1;
    exp_ovf = 1'b0;
    if (rst && wr_en) begin
      if (q.size() < DEPTH) q.push_back(wr_data);
      else exp_ovf = 1'b1;
    end
  end

  // Monitor: every launch must carry the oldest queued byte; status must match the model.
  always @(negedge clk) begin
    if (rst) begin
      if (Data_Valid) begin
        dv_total++;
        last_dv_cyc = cyc;
        age = 0;
        busy_seen = 1'b0;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL launch_when_empty: got Data_Valid=1 expected no launch (t=%0t)", $time);
        end else begin
          exp_b = q.pop_front();
          chk("launch_byte", P_DATA, exp_b);
          last_pdata = exp_b;
        end
      end else if (age < 99) begin
        age++;
        if (age <= BT - 1) busy_seen = busy_seen | busy;
      end
      chk("tx_timeout", tx_timeout, (age == BT) && !busy_seen);
      if (tx_timeout) to_total++;
      chk("wr_overflow", wr_overflow, exp_ovf);
      if (wr_overflow) ovf_total++;
      chk("count", count, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      if (busy) chk("p_data_hold", P_DATA, last_pdata);
    end
  end

  // TX controller model: busy rises the cycle after Data_Valid and lasts a frame.
  initial forever begin
    @(posedge clk);
    if (!rst) frame_left = 0;
    else if (Data_Valid && (resp_mode == 0 || (resp_mode == 2 && $urandom_range(0, 3) != 0)))
      frame_left = (frame_len > 0) ? frame_len : int'($urandom_range(1, 6));
    else if (frame_left > 0) frame_left--;
    #1 frame_busy = (frame_left > 0);
  end

  task automatic write_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = first + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_bound", n < 3000, 1'b1);
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_valid"}, Data_Valid, 1'b0);
    chk({tag, "_p_data"}, P_DATA, 8'h00);
    chk({tag, "_count"}, count, 4'd0);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_full"}, full, 1'b0);
    chk({tag, "_timeout"}, tx_timeout, 1'b0);
    chk({tag, "_overflow"}, wr_overflow, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, t0, w;
    #1 rst = 1'b0;
    #2 check_reset_outputs("reset");
    tick();
    tick();
    rst = 1'b1;

    // Idle for 50 cycles: nothing launches.
    d0 = dv_total;
    repeat (50) tick();
    chk("idle_no_launch", dv_total - d0, 0);
    chk("idle_empty", empty, 1'b1);
    chk("idle_count", count, 4'd0);

    // Single byte: Data_Valid two cycles after the write.
    resp_mode = 0;
    frame_len = 10;
    d0 = dv_total;
    wr_en = 1'b1;
    wr_data = 8'hA5;
    w = cyc;
    tick();
    wr_en = 1'b0;
    repeat (20) tick();
    chk("single_launches", dv_total - d0, 1);
    chk("single_latency", last_dv_cyc - w, 2);
    chk("single_p_data", P_DATA, 8'hA5);
    chk("single_empty_after", empty, 1'b1);

    // Burst of 9 while busy: 8 stored, 9th overflows, then drained in order.
    host_busy = 1'b1;
    tick();
    d0 = dv_total;
    t0 = ovf_total;
    write_bytes(8'h01, 9);
    tick();
    chk("burst_count", count, 4'd8);
    chk("burst_full", full, 1'b1);
    chk("burst_overflows", ovf_total - t0, 1);
    chk("burst_no_launch_busy", dv_total - d0, 0);
    host_busy = 1'b0;
    drain();
    chk("burst_launches", dv_total - d0, 8);

    // busy never rises: each launch times out and the next byte still goes.
    resp_mode = 1;
    host_busy = 1'b1;
    d0 = dv_total;
    t0 = to_total;
    write_bytes(8'h5A, 2);
    host_busy = 1'b0;
    repeat (30) tick();
    chk("timeout_pulses", to_total - t0, 2);
    chk("timeout_launches", dv_total - d0, 2);
    chk("timeout_empty", empty, 1'b1);
    resp_mode = 0;

    // Write and pop in the same cycle at count=3.
    frame_len = 6;
    host_busy = 1'b1;
    write_bytes(8'h31, 3);
    tick();
    chk("simul_pre_count", count, 4'd3);
    host_busy = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h44;
    tick();
    wr_en = 1'b0;
    chk("simul_count", count, 4'd3);
    drain();

    // Reset while a frame is on the line with 5 bytes queued.
    frame_len = 40;
    write_bytes(8'h61, 6);
    repeat (5) tick();
    chk("pre_reset_count", count, 4'd5);
    chk("pre_reset_busy", busy, 1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    q.delete();
    age = 99;
    busy_seen = 1'b0;
    last_pdata = 8'h00;
    #1 check_reset_outputs("midreset");
    tick();
    tick();
    rst = 1'b1;
    d0 = dv_total;
    repeat (15) tick();
    chk("post_reset_no_launch", dv_total - d0, 0);
    frame_len = 5;
    write_bytes(8'h77, 1);
    repeat (10) tick();
    chk("post_reset_launch", dv_total - d0, 1);
    chk("post_reset_p_data", P_DATA, 8'h77);
    drain();

    // Random traffic with random frame lengths, dropped acknowledges and busy glitches.
    resp_mode = 2;
    frame_len = 0;
    repeat (600) begin
      wr_en = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
      host_busy = ($urandom_range(0, 15) == 0);
      tick();
    end
    wr_en = 1'b0;
    host_busy = 1'b0;
    resp_mode = 0;
    frame_len = 3;
    drain();
    chk("final_empty", empty, 1'b1);
    chk("final_count", count, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
